// File: rtl/psx_n64_mapper.sv
// psx_n64_mapper: registered PSX->N64 translator with a remap table, turbo, deadzone and a stale watchdog
module psx_n64_mapper #(
    parameter int unsigned TURBO_DIV      = 4,
    parameter logic [7:0]  DEADZONE       = 8'd12,
    parameter bit          INVERT_Y       = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        psx_valid,
    input  logic [15:0] psx_btns,
    input  logic [31:0] psx_sticks,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [5:0]  cfg_data,
    output logic [15:0] n64_btns,
    output logic [15:0] n64_stick,
    output logic        map_valid,
    output logic        stale
);
    localparam int FW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0][5:0] DFLT_TBL = {6'h11, 6'h12, 6'h16, 6'h1C, 6'h00, 6'h00, 6'h00, 6'h00,
                                             6'h00, 6'h00, 6'h15, 6'h14, 6'h1B, 6'h19, 6'h18, 6'h1A};

    logic [15:0][5:0] tbl_q, tbl_d;
    logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
    logic             phase_q, phase_d, wrap;
    logic             snap_v_q;
    logic [15:0]      snap_btns_q, snap_btns_d, snap_stk_q, snap_stk_d;
    logic             snap_ph_q, snap_ph_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             expire;
    logic [15:0]      btns_q, btns_d, stick_q, stick_d, map_btns;
    logic             mv_q, stale_q, stale_d;
    logic [7:0]       x_dz, y_dz, y_out;
    logic             unused_sticks;

    assign unused_sticks = ^psx_sticks[31:16];

    function automatic logic [7:0] axis(input logic [7:0] u);
        logic [7:0] s, mag;
        s   = {~u[7], u[6:0]};
        mag = s[7] ? ~s + 8'd1 : s;
        return (mag <= DEADZONE) ? 8'd0 : s;
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_btn
        logic p;
        assign p           = tbl_q[i][4] & ~snap_btns_q[tbl_q[i][3:0]];
        assign map_btns[i] = tbl_q[i][5] ? (p & snap_ph_q) : p;
    end

    always_comb begin
        tbl_d = tbl_q;
        if (cfg_we) tbl_d[cfg_addr] = cfg_data;
        wrap        = frame_cnt_q == FW'(TURBO_DIV - 1);
        frame_cnt_d = psx_valid ? (wrap ? '0 : frame_cnt_q + FW'(1)) : frame_cnt_q;
        phase_d     = phase_q ^ (psx_valid & wrap);
        // each sample carries the phase as it stands after its own count update
        snap_ph_d   = psx_valid ? phase_d : snap_ph_q;
        snap_btns_d = psx_valid ? psx_btns : snap_btns_q;
        snap_stk_d  = psx_valid ? psx_sticks[15:0] : snap_stk_q;
        expire      = wd_q == WW'(TIMEOUT_CYCLES);
        wd_d        = psx_valid ? '0 : (expire ? wd_q : wd_q + WW'(1));
        x_dz        = axis(snap_stk_q[15:8]);
        y_dz        = axis(snap_stk_q[7:0]);
        y_out       = !INVERT_Y ? y_dz : (y_dz == 8'h80 ? 8'h7F : ~y_dz + 8'd1);
        btns_d      = snap_v_q ? map_btns : (expire ? '0 : btns_q);
        stick_d     = snap_v_q ? {x_dz, y_out} : (expire ? '0 : stick_q);
        stale_d     = snap_v_q ? 1'b0 : (expire | stale_q);
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            tbl_q       <= DFLT_TBL;
            frame_cnt_q <= '0;
            phase_q     <= 1'b1;
            snap_v_q    <= 1'b0;
            snap_btns_q <= '1;
            snap_stk_q  <= '0;
            snap_ph_q   <= 1'b1;
            wd_q        <= '0;
            btns_q      <= '0;
            stick_q     <= '0;
            mv_q        <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            tbl_q       <= tbl_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            snap_v_q    <= psx_valid;
            snap_btns_q <= snap_btns_d;
            snap_stk_q  <= snap_stk_d;
            snap_ph_q   <= snap_ph_d;
            wd_q        <= wd_d;
            btns_q      <= btns_d;
            stick_q     <= stick_d;
            mv_q        <= snap_v_q;
            stale_q     <= stale_d;
        end
    end

    assign n64_btns  = btns_q;
    assign n64_stick = stick_q;
    assign map_valid = mv_q;
    assign stale     = stale_q;
endmodule
